// File: rtl/load_store_unit_if.sv
// load_store_unit_if: memory bus between the load/store unit (master) and a memory responder (slave).
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );
    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer with alignment checks, lane steering and bus timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              is_load,
    input  logic              mem_write,
    input  logic [2:0]        load_type,
    input  logic              load_unsigned,
    input  logic [2:0]        store_type,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misalign,
    output logic              bus_err,
    load_store_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;
    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_ld_q, is_ld_d, uns_q, uns_d;
    logic [1:0]  sz_q, sz_d, lane_q, lane_d;
    logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d, rdata_q, rdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic        rdata_valid_q, rdata_valid_d, misalign_q, misalign_d, bus_err_q, bus_err_d;
    logic [1:0]  sz;
    logic        req_in, legal, aligned, accept, expired;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] rext;
    assign req_in  = is_load | mem_write;
    // funct3[1:0] encodes the access size for both loads and stores; bit 2 only marks LBU/LHU
    assign sz      = is_load ? load_type[1:0] : store_type[1:0];
    assign legal   = is_load ? (load_type[1:0] != 2'b11 && load_type[2:1] != 2'b11)
                             : (!store_type[2] && store_type[1:0] != 2'b11);
    assign aligned = sz == 2'b00 || (sz == 2'b01 && !addr[0]) || (sz == 2'b10 && addr[1:0] == 2'b00);
    assign accept  = state_q == IDLE && req_in && legal && aligned;
    assign expired = cnt_q == 8'(TIMEOUT - 1);
    assign rbyte   = 8'(bus.bus_rdata >> {lane_q, 3'b000});
    assign rhalf   = 16'(bus.bus_rdata >> {lane_q[1], 4'b0000});
    assign rext    = sz_q == 2'b00 ? {{24{!uns_q && rbyte[7]}}, rbyte}
                   : sz_q == 2'b01 ? {{16{!uns_q && rhalf[15]}}, rhalf} : bus.bus_rdata;
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_ld_d       = is_ld_q;
        uns_d         = uns_q;
        sz_d          = sz_q;
        lane_d        = lane_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        misalign_d    = 1'b0;
        bus_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = REQ;
                    cnt_d       = 8'd0;
                    is_ld_d     = is_load;
                    uns_d       = load_unsigned;
                    sz_d        = sz;
                    lane_d      = addr[1:0];
                    bus_req_d   = 1'b1;
                    bus_we_d    = !is_load;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = sz == 2'b00 ? 4'b0001 << addr[1:0]
                                : sz == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
                    bus_wdata_d = sz == 2'b00 ? {4{wdata[7:0]}} : sz == 2'b01 ? {2{wdata[15:0]}} : wdata;
                end else if (req_in) begin
                    misalign_d = 1'b1;
                end
            end
            REQ: begin
                // a grant arriving in the timeout cycle still completes the access
                if (bus.bus_gnt) begin
                    bus_req_d = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = is_ld_q ? WAIT_R : DONE;
                end else if (expired) begin
                    bus_req_d = 1'b0;
                    rdata_d   = 32'd0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_R: begin
                if (bus.bus_rvalid) begin
                    rdata_d       = rext;
                    rdata_valid_d = 1'b1;
                    state_d       = DONE;
                end else if (expired) begin
                    rdata_d   = 32'd0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            is_ld_q       <= 1'b0;
            uns_q         <= 1'b0;
            sz_q          <= 2'b00;
            lane_q        <= 2'b00;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'd0;
            bus_be_q      <= 4'd0;
            bus_wdata_q   <= 32'd0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_ld_q       <= is_ld_d;
            uns_q         <= uns_d;
            sz_q          <= sz_d;
            lane_q        <= lane_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            misalign_q    <= misalign_d;
            bus_err_q     <= bus_err_d;
        end
    end
    // the accept-cycle term is combinational, so it is gated to stay low while reset is held
    assign stall         = rst_n && (state_q == REQ || state_q == WAIT_R || accept);
    assign rdata         = rdata_q;
    assign rdata_valid   = rdata_valid_q;
    assign misalign      = misalign_q;
    assign bus_err       = bus_err_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench; the driver queues expected bus beats and responses,
// a separate monitor pops and compares them whenever the unit presents a beat or a result pulse.
module tb_load_store_unit;
    localparam int TO = 4;
    localparam logic [2:0] K_RD = 3'b100, K_MIS = 3'b010, K_ERR = 3'b001;
    typedef struct { logic we; logic [31:0] a; logic [3:0] be; logic [31:0] wd; } beat_t;
    typedef struct { logic [2:0] kind; logic [31:0] d; } resp_t;
    logic clk = 1'b0, rst_n = 1'b1;
    logic is_load = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
    logic [2:0] load_type = 3'd0, store_type = 3'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic stall, rdata_valid, misalign, bus_err;
    logic [31:0] rdata;
    int checks = 0, failures = 0;
    beat_t bq[$];
    resp_t rq[$];
    load_store_unit_if bus();
    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .is_load(is_load), .mem_write(mem_write),
        .load_type(load_type), .load_unsigned(load_unsigned), .store_type(store_type),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .misalign(misalign), .bus_err(bus_err), .bus(bus.master)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", n, act, exp);
        end
    endtask
    task automatic idle();
        is_load = 1'b0;
        mem_write = 1'b0;
    endtask
    task automatic garbage();
        is_load = 1'($urandom);
        mem_write = 1'($urandom);
        load_type = 3'($urandom);
        store_type = 3'($urandom);
        load_unsigned = 1'($urandom);
        addr = $urandom;
        wdata = $urandom;
    endtask
    // one request: gd/rd are the grant/read-data delays in cycles; >= TO means the responder never answers
    task automatic do_tx(input logic ld, input logic st, input logic [2:0] lt, input logic lu,
                         input logic [2:0] stt, input logic [31:0] a, input logic [31:0] w,
                         input int gd, input int rd, input logic [31:0] rdat);
        logic [2:0] code;
        int bytes;
        bit legal, acc, granted, ok;
        longint raw, mask;
        logic [31:0] wrep;
        @(negedge clk);
        is_load = ld; mem_write = st; load_type = lt; load_unsigned = lu;
        store_type = stt; addr = a; wdata = w;
        bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0;
        code = ld ? lt : stt;
        legal = ld ? (lt inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (stt inside {3'd0, 3'd1, 3'd2});
        bytes = 1 << code[1:0];
        acc = (ld || st) && legal && (a % bytes == 0);
        #1 chk("stall_accept", {31'd0, stall}, {31'd0, acc});
        if (!acc) begin
            if (ld || st) rq.push_back(resp_t'{K_MIS, 32'd0});
            @(posedge clk);
            @(negedge clk);
            idle();
            #1 chk("bus_req_after_reject", {31'd0, bus.bus_req}, 32'd0);
            chk("stall_after_reject", {31'd0, stall}, 32'd0);
            return;
        end
        raw = longint'(rdat) >> (8 * (a % 4));
        mask = (longint'(1) << (8 * bytes)) - 1;
        raw = raw & mask;
        if (!lu && bytes < 4 && raw[8 * bytes - 1]) raw = raw | ~mask;
        wrep = bytes == 1 ? (w & 32'hFF) * 32'h0101_0101 : bytes == 2 ? (w & 32'hFFFF) * 32'h0001_0001 : w;
        granted = gd < TO;
        ok = granted && (!ld || rd < TO);
        if (granted) bq.push_back(beat_t'{!ld, a - (a % 4), 4'(((1 << bytes) - 1) << (a % 4)), wrep});
        if (!ok) rq.push_back(resp_t'{K_ERR, 32'd0});
        else if (ld) rq.push_back(resp_t'{K_RD, raw[31:0]});
        @(posedge clk);
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            garbage();
            bus.bus_gnt = (c == gd);
            bus.bus_rvalid = 1'($urandom);
            bus.bus_rdata = $urandom;
            #1 chk("stall_in_req", {31'd0, stall}, 32'd1);
            @(posedge clk);
            if (c == gd) break;
        end
        if (granted && ld) begin
            for (int c = 0; c < TO; c++) begin
                @(negedge clk);
                garbage();
                bus.bus_gnt = 1'b0;
                bus.bus_rvalid = (c == rd);
                bus.bus_rdata = (c == rd) ? rdat : $urandom;
                #1 chk("stall_in_wait_r", {31'd0, stall}, 32'd1);
                chk("bus_req_after_gnt", {31'd0, bus.bus_req}, 32'd0);
                @(posedge clk);
                if (c == rd) break;
            end
        end
        @(negedge clk);
        idle();
        bus.bus_gnt = 1'b0;
        bus.bus_rvalid = 1'($urandom);
        bus.bus_rdata = $urandom;
        #1 chk("stall_after_access", {31'd0, stall}, 32'd0);
        chk("bus_req_after_access", {31'd0, bus.bus_req}, 32'd0);
        if (ok) @(posedge clk);
    endtask
    task automatic reset_mid_load();
        @(negedge clk);
        is_load = 1'b1; mem_write = 1'b0; load_type = 3'b010; load_unsigned = 1'b0; addr = 32'h200;
        bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0;
        bq.push_back(beat_t'{1'b0, 32'h200, 4'hF, 32'd0});
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.bus_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bus_gnt = 1'b0;
        #1 chk("stall_wait_r_pre_reset", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1 chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
        chk("rst_bus_addr_be", {bus.bus_addr[27:0], bus.bus_be}, 32'd0);
        chk("rst_pulses", {29'd0, rdata_valid, misalign, bus_err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_write = 1'b1; store_type = 3'b000; addr = 32'h301; wdata = 32'h1234_565A;
        bus.bus_rvalid = 1'b1;
        bus.bus_rdata = $urandom;
        bq.push_back(beat_t'{1'b1, 32'h300, 4'b0010, 32'h5A5A_5A5A});
        #1 chk("stall_first_accept", {31'd0, stall}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.bus_rvalid = 1'b0;
        bus.bus_gnt = 1'b1;
        #1 chk("first_accept_after_reset", {31'd0, bus.bus_req}, 32'd1);
        chk("no_late_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.bus_gnt = 1'b0;
        #1 chk("no_rdata_valid_store_done", {31'd0, rdata_valid}, 32'd0);
        @(posedge clk);
    endtask
    initial forever begin
        @(negedge clk);
        #2;
        if (bus.bus_req && bus.bus_gnt) begin
            if (bq.size() == 0) chk("unexpected_bus_beat", 32'd1, 32'd0);
            else begin
                beat_t b;
                b = bq.pop_front();
                chk("bus_we", {31'd0, bus.bus_we}, {31'd0, b.we});
                chk("bus_addr", bus.bus_addr, b.a);
                chk("bus_be", {28'd0, bus.bus_be}, {28'd0, b.be});
                if (b.we) chk("bus_wdata", bus.bus_wdata, b.wd);
            end
        end
        if (rdata_valid || misalign || bus_err) begin
            if (rq.size() == 0) chk("unexpected_response", {29'd0, rdata_valid, misalign, bus_err}, 32'd0);
            else begin
                resp_t r;
                r = rq.pop_front();
                chk("response_kind", {29'd0, rdata_valid, misalign, bus_err}, {29'd0, r.kind});
                if (r.kind != K_MIS) chk("response_rdata", rdata, r.d);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench exceeded its time limit");
    end
    initial begin
        int lts[5] = '{0, 1, 2, 4, 5};
        bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'd0;
        #1 rst_n = 1'b0;
        #1 chk("reset_pulses", {29'd0, rdata_valid, misalign, bus_err}, 32'd0);
        chk("reset_stall_req", {30'd0, stall, bus.bus_req}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_tx(1'b0, 1'b1, 3'd0, 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'd0);
        do_tx(1'b1, 1'b0, 3'b000, 1'b0, 3'd0, 32'h103, 32'd0, 0, 0, 32'h80FF_1234);
        do_tx(1'b1, 1'b0, 3'b100, 1'b1, 3'd0, 32'h103, 32'd0, 0, 0, 32'h80FF_1234);
        do_tx(1'b0, 1'b1, 3'd0, 1'b0, 3'b001, 32'h102, 32'h0000_ABCD, 0, 0, 32'd0);
        do_tx(1'b1, 1'b0, 3'b010, 1'b0, 3'd0, 32'h101, 32'd0, 0, 0, 32'd0);
        do_tx(1'b1, 1'b0, 3'b010, 1'b0, 3'd0, 32'h104, 32'd0, 99, 0, 32'd0);
        do_tx(1'b1, 1'b0, 3'b001, 1'b0, 3'd0, 32'h106, 32'd0, 0, 99, 32'h1234_5678);
        do_tx(1'b1, 1'b0, 3'b101, 1'b1, 3'd0, 32'h10A, 32'd0, TO - 1, TO - 1, 32'hF00D_8001);
        do_tx(1'b1, 1'b1, 3'b001, 1'b0, 3'b010, 32'h202, 32'h5555_5555, 1, 2, 32'h8765_4321);
        do_tx(1'b1, 1'b0, 3'b011, 1'b0, 3'd0, 32'h200, 32'd0, 0, 0, 32'd0);
        do_tx(1'b0, 1'b1, 3'd0, 1'b0, 3'b011, 32'h200, 32'd0, 0, 0, 32'd0);
        reset_mid_load();
        for (int i = 0; i < 250; i++) begin
            logic ld, st, lu;
            logic [2:0] lt, stt;
            logic [31:0] a;
            int gd, rd;
            ld = 1'($urandom);
            st = ld ? 1'($urandom) : ($urandom % 10 != 0);
            lt = ($urandom % 6 == 0) ? 3'($urandom) : 3'(lts[$urandom % 5]);
            lu = lt[2];
            stt = ($urandom % 6 == 0) ? 3'($urandom) : 3'($urandom % 3);
            a = $urandom;
            if ($urandom % 3 != 0) a[1:0] = 2'b00;
            gd = ($urandom % 8 == 0) ? TO + int'($urandom % 2) : int'($urandom % TO);
            rd = ($urandom % 8 == 0) ? TO + int'($urandom % 2) : int'($urandom % TO);
            do_tx(ld, st, lt, lu, stt, a, $urandom, gd, rd, $urandom);
        end
        repeat (4) @(posedge clk);
        chk("scoreboard_drain", bq.size() + rq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
